// File: rtl/mcb_port_pkg.sv
// Shared definitions for the MCB user-port responder.
// Holds the 3-bit command opcode type with its named values and the
// engine state encoding used by mcb_port_responder.
package mcb_port_pkg;

  typedef logic [2:0] cmd_instr_t;

  localparam cmd_instr_t CMD_WRITE    = 3'b000;
  localparam cmd_instr_t CMD_READ     = 3'b001;
  localparam cmd_instr_t CMD_WRITE_PC = 3'b010;
  localparam cmd_instr_t CMD_READ_PC  = 3'b011;
  localparam cmd_instr_t CMD_REFRESH  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_REFRESH
  } state_t;

endpackage

// File: rtl/mcb_port_responder_if.sv
// User-port bundle between a memory controller (master) and the responder
// (slave): command channel, write-data channel and read-data channel with
// their FIFO status flags and counts.
interface mcb_port_responder_if;

  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [27:0] cmd_word_addr;
  logic        cmd_empty;
  logic        cmd_full;

  logic        wr_en;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;
  logic        wr_full;
  logic        wr_empty;
  logic [6:0]  wr_count;
  logic        wr_underrun;
  logic        wr_error;

  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_full;
  logic        rd_empty;
  logic [6:0]  rd_count;
  logic        rd_overflow;
  logic        rd_error;

  modport master (
    output cmd_en, cmd_instr, cmd_bl, cmd_word_addr,
    input  cmd_empty, cmd_full,
    output wr_en, wr_mask, wr_data,
    input  wr_full, wr_empty, wr_count, wr_underrun, wr_error,
    output rd_en,
    input  rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error
  );

  modport slave (
    input  cmd_en, cmd_instr, cmd_bl, cmd_word_addr,
    output cmd_empty, cmd_full,
    input  wr_en, wr_mask, wr_data,
    output wr_full, wr_empty, wr_count, wr_underrun, wr_error,
    input  rd_en,
    output rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error
  );

endinterface

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports: clk, rst_n (sync, active-low), push/din, pop/dout, full, empty,
// count (0..2^AW). dout shows the head entry and reads as zero when empty.
// Push while full and pop while empty are ignored.
module sync_fwft_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mcb_port_responder.sv
// Memory-port responder: accepts MCB-style commands and data through three
// FIFOs and services them from an internal 32-bit word RAM.
// Ports: clk, rst_n (sync, active-low), port (slave side of
// mcb_port_responder_if: command, write-data and read-data channels).
// Write bursts pop one word per cycle and stall while the write FIFO is
// empty; read bursts never stall and drop words when the read FIFO is full.
module mcb_port_responder
  import mcb_port_pkg::*;
#(
  parameter int MEM_AW         = 10,
  parameter int CMD_DEPTH_AW   = 2,
  parameter int DATA_DEPTH_AW  = 6,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mcb_port_responder_if.slave  port
);

  localparam int CMD_W     = 3 + 6 + MEM_AW;
  localparam int RAM_DEPTH = 1 << MEM_AW;

  // Command FIFO: {instr, bl, addr[MEM_AW-1:0]}
  logic [CMD_W-1:0]      cmd_din, cmd_dout;
  logic                  cmd_pop;
  logic [CMD_DEPTH_AW:0] cmd_count_unused;
  logic                  unused_addr_hi;

  assign cmd_din        = {port.cmd_instr, port.cmd_bl, port.cmd_word_addr[MEM_AW-1:0]};
  assign unused_addr_hi = ^port.cmd_word_addr[27:MEM_AW];

  sync_fwft_fifo #(.WIDTH(CMD_W), .AW(CMD_DEPTH_AW)) u_cmd_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(port.cmd_en), .din(cmd_din),
    .pop(cmd_pop), .dout(cmd_dout),
    .full(port.cmd_full), .empty(port.cmd_empty), .count(cmd_count_unused)
  );

  // Write FIFO: {mask, data}
  logic [35:0]            wr_head;
  logic                   wr_pop;
  logic [DATA_DEPTH_AW:0] wr_cnt;

  sync_fwft_fifo #(.WIDTH(36), .AW(DATA_DEPTH_AW)) u_wr_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(port.wr_en), .din({port.wr_mask, port.wr_data}),
    .pop(wr_pop), .dout(wr_head),
    .full(port.wr_full), .empty(port.wr_empty), .count(wr_cnt)
  );
  assign port.wr_count = 7'(wr_cnt);

  // Read FIFO, fed by the RAM read pipeline one cycle after each issue
  logic [31:0]            ram_rd_word;
  logic                   rd_vld_q, rd_vld_d;
  logic [DATA_DEPTH_AW:0] rd_cnt;

  sync_fwft_fifo #(.WIDTH(32), .AW(DATA_DEPTH_AW)) u_rd_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(rd_vld_q), .din(ram_rd_word),
    .pop(port.rd_en), .dout(port.rd_data),
    .full(port.rd_full), .empty(port.rd_empty), .count(rd_cnt)
  );
  assign port.rd_count = 7'(rd_cnt);

  // Burst engine
  state_t            state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [6:0]        n_q, n_d;
  logic [6:0]        i_q, i_d;
  logic              underrun_q, underrun_d;
  logic              overflow_q, overflow_d;
  logic              ram_we, ram_re;
  logic [MEM_AW-1:0] cur_addr;
  cmd_instr_t        head_instr;
  logic [5:0]        head_bl;

  assign head_instr = cmd_dout[CMD_W-1 -: 3];
  assign head_bl    = cmd_dout[MEM_AW +: 6];
  assign cur_addr   = addr_q + MEM_AW'(i_q);  // wraps modulo RAM depth

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    n_d        = n_q;
    i_d        = i_q;
    cmd_pop    = 1'b0;
    wr_pop     = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    underrun_d = underrun_q;
    overflow_d = overflow_q | (rd_vld_q & port.rd_full);
    case (state_q)
      ST_IDLE: begin
        if (!port.cmd_empty) begin
          cmd_pop = 1'b1;
          addr_d  = cmd_dout[MEM_AW-1:0];
          n_d     = {1'b0, head_bl} + 7'd1;
          i_d     = '0;
          case (head_instr)
            CMD_WRITE, CMD_WRITE_PC: state_d = ST_WRITE;
            CMD_READ, CMD_READ_PC:   state_d = ST_READ;
            CMD_REFRESH:             state_d = ST_REFRESH;
            default:                 state_d = ST_IDLE;  // unknown opcode discarded
          endcase
        end
      end
      ST_WRITE: begin
        if (port.wr_empty) begin
          underrun_d = 1'b1;
        end else begin
          wr_pop = 1'b1;
          ram_we = 1'b1;
          i_d    = i_q + 7'd1;
          if (i_q + 7'd1 == n_q) state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        // One extra cycle after the last issue lets the final word land.
        if (i_q != n_q) begin
          ram_re = 1'b1;
          i_d    = i_q + 7'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REFRESH: begin
        // i counts refresh cycles here; it is reloaded on the next command.
        i_d = i_q + 7'd1;
        if (i_q == 7'(REFRESH_CYCLES - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rd_vld_d = ram_re;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      n_q        <= '0;
      i_q        <= '0;
      rd_vld_q   <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      n_q        <= n_d;
      i_q        <= i_d;
      rd_vld_q   <= rd_vld_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  // RAM split into byte lanes so the write mask maps onto per-lane enables.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_byte_lane
    logic [7:0] ram_b [RAM_DEPTH];
    logic [7:0] rd_byte_q;
    always_ff @(posedge clk) begin
      if (ram_we && !wr_head[32+gi]) ram_b[cur_addr] <= wr_head[8*gi +: 8];
      if (ram_re) rd_byte_q <= ram_b[cur_addr];
    end
    assign ram_rd_word[8*gi +: 8] = rd_byte_q;
  end

  assign port.wr_underrun = underrun_q;
  assign port.rd_overflow = overflow_q;
  assign port.wr_error    = 1'b0;
  assign port.rd_error    = 1'b0;

endmodule

// File: tb/tb_mcb_port_responder.sv
module tb_mcb_port_responder;
  import mcb_port_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mcb_port_responder_if bus();

  mcb_port_responder #(
    .MEM_AW(10), .CMD_DEPTH_AW(2), .DATA_DEPTH_AW(6), .REFRESH_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .port(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    cmd_instr_t  wr_op;
    cmd_instr_t  rd_op;
    logic [27:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp;
  } wvec_t;

  wvec_t vecs [6];

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) cycle();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [31:0] d, input logic [3:0] m);
    bus.wr_en = 1'b1; bus.wr_data = d; bus.wr_mask = m;
    cycle();
    bus.wr_en = 1'b0;
  endtask

  task automatic push_cmd(input cmd_instr_t op, input logic [5:0] bl, input logic [27:0] addr);
    $display("cmd op=%0d bl=%0d addr=0x%07h accepted=%0d", op, bl, addr, !bus.cmd_full);
    bus.cmd_en = 1'b1; bus.cmd_instr = op; bus.cmd_bl = bl; bus.cmd_word_addr = addr;
    cycle();
    bus.cmd_en = 1'b0;
  endtask

  task automatic pop_rd(input string name, input logic [31:0] exp);
    check(name, bus.rd_data, exp);
    bus.rd_en = 1'b1;
    cycle();
    bus.rd_en = 1'b0;
  endtask

  task automatic wait_rd_count(input string name, input logic [6:0] target, input int budget);
    int n = 0;
    while (bus.rd_count != target && n < budget) begin
      cycle();
      n++;
    end
    check(name, {25'd0, bus.rd_count}, {25'd0, target});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{CMD_WRITE,    CMD_READ,    28'h0000005,  32'hFFFF_FFFF, 4'b0000, 32'hFFFF_FFFF};
    vecs[1] = '{CMD_WRITE_PC, CMD_READ_PC, 28'h0000005,  32'h1234_5678, 4'b0101, 32'h12FF_56FF};
    vecs[2] = '{CMD_WRITE,    CMD_READ_PC, 28'h0000021,  32'h1122_3344, 4'b0000, 32'h1122_3344};
    vecs[3] = '{CMD_WRITE_PC, CMD_READ,    28'h0000021,  32'hAABB_CCDD, 4'b1010, 32'h11BB_33DD};
    vecs[4] = '{CMD_WRITE,    CMD_READ,    28'hFFFFC20,  32'hDEAD_BEEF, 4'b0000, 32'hDEAD_BEEF};
    vecs[5] = '{CMD_WRITE,    CMD_READ,    28'h0000020,  32'h0000_0000, 4'b1111, 32'hDEAD_BEEF};

    bus.cmd_en = 0; bus.cmd_instr = '0; bus.cmd_bl = '0; bus.cmd_word_addr = '0;
    bus.wr_en = 0; bus.wr_mask = '0; bus.wr_data = '0; bus.rd_en = 0;

    // Reset state
    settle(3);
    check("rst_cmd_empty", bus.cmd_empty, 1);
    check("rst_cmd_full", bus.cmd_full, 0);
    check("rst_wr_empty", bus.wr_empty, 1);
    check("rst_wr_full", bus.wr_full, 0);
    check("rst_rd_empty", bus.rd_empty, 1);
    check("rst_rd_full", bus.rd_full, 0);
    check("rst_wr_count", bus.wr_count, 0);
    check("rst_rd_count", bus.rd_count, 0);
    check("rst_flags", {bus.wr_underrun, bus.rd_overflow, bus.wr_error, bus.rd_error}, 0);
    check("rst_rd_data", bus.rd_data, 0);
    rst_n = 1'b1;
    cycle();

    // Basic write then read
    for (int k = 0; k < 4; k++) push_wr(32'hA0 + k, 4'b0000);
    check("basic_wr_count", bus.wr_count, 4);
    push_cmd(CMD_WRITE_PC, 6'd3, 28'h10);
    push_cmd(CMD_READ_PC, 6'd3, 28'h10);
    wait_rd_count("basic_rd_count", 7'd4, 100);
    for (int k = 0; k < 4; k++) pop_rd("basic_data", 32'hA0 + k);
    check("basic_rd_empty", bus.rd_empty, 1);

    // Table: single-word write immediately followed by read-back
    foreach (vecs[v]) begin
      push_wr(vecs[v].data, vecs[v].mask);
      push_cmd(vecs[v].wr_op, 6'd0, vecs[v].addr);
      push_cmd(vecs[v].rd_op, 6'd0, vecs[v].addr);
      wait_rd_count($sformatf("vec%0d_count", v), 7'd1, 50);
      pop_rd($sformatf("vec%0d_data", v), vecs[v].exp);
    end
    check("no_underrun_yet", bus.wr_underrun, 0);

    // Underrun: burst of 8 with only 3 words queued
    for (int k = 0; k < 3; k++) push_wr(32'hB0 + k, 4'b0000);
    push_cmd(CMD_WRITE, 6'd7, 28'h40);
    settle(10);
    check("underrun_flag", bus.wr_underrun, 1);
    check("underrun_wr_empty", bus.wr_empty, 1);
    push_cmd(CMD_READ, 6'd7, 28'h40);
    settle(10);
    check("underrun_stall", bus.rd_count, 0);
    for (int k = 3; k < 8; k++) push_wr(32'hB0 + k, 4'b0000);
    wait_rd_count("underrun_rd_count", 7'd8, 100);
    for (int k = 0; k < 8; k++) pop_rd("underrun_data", 32'hB0 + k);

    // Overflow: two 64-word reads without draining
    push_cmd(CMD_READ, 6'd63, 28'h0);
    push_cmd(CMD_READ, 6'd63, 28'h0);
    wait_rd_count("ovf_first_fill", 7'd64, 200);
    check("ovf_not_yet", bus.rd_overflow, 0);
    settle(80);
    check("ovf_count", bus.rd_count, 64);
    check("ovf_full", bus.rd_full, 1);
    check("ovf_flag", bus.rd_overflow, 1);
    for (int k = 0; k < 64; k++) begin
      case (k)
        5:  check("drain_w05", bus.rd_data, 32'h12FF_56FF);
        16: check("drain_w10", bus.rd_data, 32'hA0);
        19: check("drain_w13", bus.rd_data, 32'hA3);
        32: check("drain_w20", bus.rd_data, 32'hDEAD_BEEF);
        33: check("drain_w21", bus.rd_data, 32'h11BB_33DD);
        default: ;
      endcase
      bus.rd_en = 1'b1;
      cycle();
    end
    bus.rd_en = 1'b0;
    check("drain_empty", bus.rd_empty, 1);
    check("drain_count", bus.rd_count, 0);
    bus.rd_en = 1'b1;
    settle(3);
    bus.rd_en = 1'b0;
    check("extra_pop_count", bus.rd_count, 0);
    check("extra_pop_empty", bus.rd_empty, 1);
    check("extra_pop_data", bus.rd_data, 0);

    // Address wrap, then command FIFO full with the engine stalled
    for (int k = 0; k < 4; k++) push_wr(32'hC0 + k, 4'b0000);
    push_cmd(CMD_WRITE, 6'd3, 28'h3FE);
    settle(8);
    push_cmd(CMD_WRITE, 6'd0, 28'h100);  // stalls: write FIFO empty
    settle(3);
    push_cmd(CMD_READ, 6'd0, 28'h3FE);
    push_cmd(CMD_READ, 6'd0, 28'h3FF);
    push_cmd(CMD_READ, 6'd0, 28'h000);
    push_cmd(CMD_READ, 6'd0, 28'h001);
    check("cmd_full", bus.cmd_full, 1);
    push_cmd(CMD_READ, 6'd0, 28'h3FE);   // dropped
    check("cmd_full_hold", bus.cmd_full, 1);
    push_wr(32'h5A5A_5A5A, 4'b0000);
    wait_rd_count("wrap_rd_count", 7'd4, 100);
    settle(20);
    check("wrap_only_four", bus.rd_count, 4);
    for (int k = 0; k < 4; k++) pop_rd("wrap_data", 32'hC0 + k);
    check("wrap_cmd_empty", bus.cmd_empty, 1);

    // Reset in the middle of a read burst
    push_cmd(CMD_READ, 6'd63, 28'h0);
    push_cmd(CMD_READ, 6'd63, 28'h0);
    begin
      int n = 0;
      while (bus.rd_count < 7'd5 && n < 50) begin cycle(); n++; end
      check("midrst_started", {31'd0, bus.rd_count >= 7'd5}, 1);
    end
    rst_n = 1'b0;
    cycle();
    check("midrst_rd_empty", bus.rd_empty, 1);
    check("midrst_rd_count", bus.rd_count, 0);
    check("midrst_cmd_empty", bus.cmd_empty, 1);
    check("midrst_wr_empty", bus.wr_empty, 1);
    check("midrst_flags", {bus.wr_underrun, bus.rd_overflow}, 0);
    rst_n = 1'b1;
    settle(10);
    check("midrst_quiet", bus.rd_count, 0);
    check("midrst_quiet_empty", bus.rd_empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcb_port_responder.md
Name: mcb_port_responder

Overview:
- Synthesizable responder for one MCB/MIG-style user port: command FIFO, write-data FIFO and read-data FIFO, backed by an internal word-addressed RAM.
- It is the target that ddr3_controller drives. It is used in simulation and in on-chip loopback builds in place of the real memory port, so the Wishbone DDR3 path can be exercised without external DRAM.

Parameters:
- MEM_AW, 10, log2 of RAM depth in 32-bit words. Word address is taken modulo 2^MEM_AW.
- CMD_DEPTH_AW, 2, log2 of command FIFO depth (4 entries).
- DATA_DEPTH_AW, 6, log2 of write and read data FIFO depth (64 entries each).
- REFRESH_CYCLES, 8, busy cycles consumed by a refresh command.

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  reset, synchronous, active-low
- cmd_en  in  1  command strobe
- cmd_instr  in  3  000 WR, 001 RD, 010 WR_PC, 011 RD_PC, 100 REFRESH
- cmd_bl  in  6  burst length minus 1 (1..64 words)
- cmd_word_addr  in  28  starting word address
- cmd_empty  out  1  command FIFO empty
- cmd_full  out  1  command FIFO full
- wr_en  in  1  write-data strobe
- wr_mask  in  4  byte mask; a bit set to 1 suppresses that byte
- wr_data  in  32  write data
- wr_full  out  1  write FIFO full
- wr_empty  out  1  write FIFO empty
- wr_count  out  7  words held in write FIFO (0..64)
- wr_underrun  out  1  sticky: a write burst found the write FIFO empty
- wr_error  out  1  tied 0 (single clock domain, pointers cannot desync)
- rd_en  in  1  read-data pop
- rd_data  out  32  head of read FIFO, first-word-fall-through
- rd_full  out  1  read FIFO full
- rd_empty  out  1  read FIFO empty
- rd_count  out  7  words held in read FIFO (0..64)
- rd_overflow  out  1  sticky: a read word was dropped because the read FIFO was full
- rd_error  out  1  tied 0

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All FIFOs are emptied. cmd_empty=1, wr_empty=1, rd_empty=1; cmd_full=0, wr_full=0, rd_full=0.
  - wr_count=0, rd_count=0; wr_underrun=0, rd_overflow=0.
  - FSM returns to IDLE. rd_data=0 while the read FIFO is empty.
  - RAM contents are undefined and are not cleared.
  - A reset mid-burst abandons the burst immediately.
- FIFO push/pop rules:
  - A FIFO pushes on strobe && !full. A strobe while full is silently dropped and the count is unchanged.
  - A FIFO pops on pop && !empty. A pop while empty is ignored.
  - Simultaneous push and pop on a non-empty FIFO leaves the count unchanged.
  - Counts and flags are registered and update on the same edge as the push or pop.
  - Write FIFO entry = {wr_mask, wr_data}. Command FIFO entry = {instr, bl, addr[MEM_AW-1:0]}.
- FSM states:
  - IDLE: if the command FIFO is not empty, pop the head. Latch addr, n=bl+1, i=0. Go to WRITE (WR/WR_PC), READ (RD/RD_PC), or REFRESH (instr 100). Any other opcode is popped and discarded.
  - WRITE, per cycle:
    - If the write FIFO is not empty: pop one word and write it to RAM[(addr+i) mod 2^MEM_AW] with the byte mask applied; i++.
    - If the write FIFO is empty: set wr_underrun and stall in WRITE until data arrives.
    - When i==n, go to IDLE.
  - READ, per cycle:
    - Issue RAM read of (addr+i) with 1-cycle latency. Push the returned word into the read FIFO on the following cycle.
    - If the read FIFO is full at push time, the word is dropped and rd_overflow is set. The engine never stalls on a read.
    - Go to IDLE after the final push, so a read burst takes n+1 cycles.
  - REFRESH: wait REFRESH_CYCLES cycles, then go to IDLE.
- Ordering and hazards:
  - Commands execute strictly in order.
  - Write data reaches RAM before any later read command samples it.
  - A read that immediately follows a write to the same address returns the new data, because RAM write and read are sequential states.
- Address arithmetic:
  - addr+i wraps modulo 2^MEM_AW.
  - The upper cmd_word_addr bits are ignored.
  - The PC and non-PC variants of an opcode behave identically.
- Throughput: best case one data word per cycle in WRITE and READ, plus one IDLE cycle per command.

Decomposition:
- Package mcb_port_pkg holds:
  - the CMD_WRITE, CMD_READ, CMD_WRITE_PC, CMD_READ_PC and CMD_REFRESH constants;
  - the FSM state encoding (IDLE, WRITE, READ, REFRESH);
  - the 3-bit instruction typedef.
- One sub-module, sync_fwft_fifo (parameters WIDTH, AW; outputs full, empty, count), instantiated three times: command FIFO, write FIFO, read FIFO.
- The RAM is inferred inside the top level.

Test Plan:
- Basic write then read: reset, push 4 words 0xA0..0xA3 with mask 0, issue WR_PC bl=3 addr=0x10, then RD_PC bl=3 addr=0x10 -> rd_count reaches 4 and rd_data pops 0xA0, 0xA1, 0xA2, 0xA3; rd_empty=1 after the last pop.
- Byte mask: write 0xFFFFFFFF to addr 5, then write 0x12345678 with mask 4'b0101 -> a read of addr 5 returns 0x12FF56FF.
- Underrun: issue WR bl=7 with only 3 words queued -> wr_underrun=1 and the FSM stalls; push 5 more words -> burst completes, and a read of those 8 words returns them in order.
- Overflow and boundary:
  - Issue RD bl=63 twice without draining -> rd_count=64, rd_full=1, rd_overflow=1 from the first word of the second burst.
  - Extra rd_en with rd_empty=1 after a full drain -> counts unchanged.
- Wrap and full queues: with MEM_AW=10, a write of bl=3 at addr 0x3FE lands at words 0x3FE, 0x3FF, 0x000, 0x001 (read-back matches). A 5th cmd_en while cmd_full=1 is dropped, so only 4 commands execute.
- Reset mid-burst: assert rst_n=0 during a READ burst -> next cycle all FIFOs are empty, flags are 0, FSM is IDLE, and no further rd_count change occurs.
